// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: instruction codes, status codes
// and the memory-access FSM state type.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam int unsigned WORD_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic logic is_read_icode(input logic [3:0] ic);
        return (ic == ICODE_MRMOVQ) || (ic == ICODE_RET) || (ic == ICODE_POPQ);
    endfunction

    function automatic logic is_write_icode(input logic [3:0] ic);
        return (ic == ICODE_RMMOVQ) || (ic == ICODE_CALL) || (ic == ICODE_PUSHQ);
    endfunction

    // ret and popq address memory through the stack pointer value in valA.
    function automatic logic uses_vala_addr(input logic [3:0] ic);
        return (ic == ICODE_RET) || (ic == ICODE_POPQ);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte sequencer for one 64-bit access: walks the byte index, selects the outgoing
// write byte and assembles the little-endian read word.
module mem_byte_lane
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] wdata,
    input  logic        step,
    input  logic        capture_rd,
    input  logic        clear,
    input  logic [7:0]  rdata,
    output logic [2:0]  idx,
    output logic        last,
    output logic [7:0]  wbyte,
    output logic [63:0] valm
);

    logic [63:0] data;

    // start also clears valm so that writes and rejected instructions report zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= 3'd0;
            data <= 64'd0;
            valm <= 64'd0;
        end else if (start) begin
            idx  <= 3'd0;
            data <= wdata;
            valm <= 64'd0;
        end else if (clear) begin
            idx  <= 3'd0;
            valm <= 64'd0;
        end else if (step) begin
            if (capture_rd) begin
                valm[{idx, 3'b000} +: 8] <= rdata;
            end
            idx <= idx + 3'd1;
        end
    end

    assign last  = (idx == 3'(WORD_BYTES - 1));
    assign wbyte = data[{idx, 3'b000} +: 8];

endmodule

// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage initiator: one instruction at a time, eight byte transactions
// on a req/ack port. Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import y86_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [63:0]       valE,
    input  logic [63:0]       valA,
    input  logic [63:0]       valP,
    input  logic              Instr_valid,
    input  logic              imem_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic [63:0]       valM,
    output logic [1:0]        stat
);

    // Highest base address whose full 8-byte word still fits in memory.
    localparam logic [63:0] ADDR_MAX = (64'd1 << ADDR_W) - 64'd8;

    state_t state;
    state_t state_next;

    logic              capture;
    logic              rd_ic;
    logic              wr_ic;
    logic              acc_ic;
    logic [63:0]       acc_addr;
    logic [63:0]       acc_data;
    logic              addr_bad;
    logic [1:0]        stat_dec;
    logic              go_access;

    logic [ADDR_W-1:0] base;
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        stat_q;

    logic              ack_ok;
    logic              timed_out;
    logic [2:0]        idx;
    logic              last;
    logic [7:0]        wbyte;

    assign capture = (state == ST_IDLE) && in_valid;

    // Instruction decode and error classification, evaluated on the capture cycle.
    always_comb begin
        rd_ic    = is_read_icode(icode);
        wr_ic    = is_write_icode(icode);
        acc_ic   = rd_ic || wr_ic;
        acc_addr = uses_vala_addr(icode) ? valA : valE;
        acc_data = (icode == ICODE_CALL) ? valP : valA;
        addr_bad = (acc_addr > ADDR_MAX);

        stat_dec = STAT_AOK;
        if (imem_error) begin
            stat_dec = STAT_ADR;
        end else if (!Instr_valid) begin
            stat_dec = STAT_INS;
        end else if (icode == ICODE_HALT) begin
            stat_dec = STAT_HLT;
        end else if (acc_ic && addr_bad) begin
            stat_dec = STAT_ADR;
        end
        go_access = acc_ic && (stat_dec == STAT_AOK);
    end

    assign ack_ok = (state == ST_ACCESS) && mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Counts consecutive un-acked request cycles; any ack or leaving ACCESS clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if ((state == ST_ACCESS) && !mem_ack) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timed_out = (state == ST_ACCESS) && !mem_ack &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mem_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = go_access ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                mem_req = 1'b1;
                if (mem_ack && last) begin
                    state_next = ST_RESP;
                end else if (timed_out) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                out_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction context held for the whole access; stat survives until the next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base   <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            stat_q <= STAT_AOK;
        end else if (capture) begin
            base   <= acc_addr[ADDR_W-1:0];
            wr_q   <= wr_ic;
            rd_q   <= rd_ic;
            stat_q <= stat_dec;
        end else if (timed_out) begin
            stat_q <= STAT_ADR;
        end
    end

    mem_byte_lane u_lane (
        .clk        (clk),
        .rst        (rst),
        .start      (capture),
        .wdata      (acc_data),
        .step       (ack_ok),
        .capture_rd (rd_q),
        .clear      (timed_out),
        .rdata      (mem_rdata),
        .idx        (idx),
        .last       (last),
        .wbyte      (wbyte),
        .valm       (valM)
    );

    assign mem_we    = mem_req && wr_q;
    assign mem_addr  = base + ADDR_W'(idx);
    assign mem_wdata = wbyte;
    assign stat      = stat_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset/timeout
// sequences and randomized instructions against a word-level memory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        Instr_valid;
    logic        imem_error;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_ack = 1'b0;
    logic        out_valid;
    logic [63:0] valM;
    logic [1:0]  stat;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .icode       (icode),
        .valE        (valE),
        .valA        (valA),
        .valP        (valP),
        .Instr_valid (Instr_valid),
        .imem_error  (imem_error),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .out_valid   (out_valid),
        .valM        (valM),
        .stat        (stat)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] tb_mem  [0:65535];
    logic [7:0] ref_mem [0:65535];

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t act_log[$];
    txn_t exp_log[$];

    int waits_cfg[8];
    bit hold_low   = 1'b0;
    int byte_no    = 0;
    int waited     = 0;
    int req_cycles = 0;

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] e;
        logic [63:0] a;
        logic [63:0] p;
        bit          iv;
        bit          im;
        int          wait_byte;
        int          wait_n;
        logic [1:0]  exp_stat;
        logic [63:0] exp_valm;
        int          exp_cyc;
        int          exp_nreq;
    } vec_t;

    vec_t vecs[$];

    // Memory responder: decides ack at the falling edge, commits at the rising edge.
    always @(negedge clk) begin
        if (mem_req) begin
            if (hold_low || waited < waits_cfg[byte_no % 8]) begin
                mem_ack = 1'b0;
                waited++;
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = tb_mem[mem_addr];
            end
        end else begin
            mem_ack   = 1'b1;
            mem_rdata = 8'($urandom);
        end
    end

    always @(posedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (mem_ack) begin
                act_log.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
                if (mem_we) tb_mem[mem_addr] = mem_wdata;
                byte_no++;
                waited = 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Word-level reference: classifies the instruction and applies its effect to ref_mem.
    task automatic model_instr(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                               input logic [63:0] p, input bit iv, input bit im,
                               output logic [1:0] st, output logic [63:0] vm, output bit acc);
        bit          rd;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [15:0] ad;
        rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data = (ic == 4'h8) ? p : a;
        vm   = 64'd0;
        exp_log.delete();
        if (im)                                  st = 2'b10;
        else if (!iv)                            st = 2'b11;
        else if (ic == 4'h0)                     st = 2'b01;
        else if ((rd || wr) && addr > 64'd65528) st = 2'b10;
        else                                     st = 2'b00;
        acc = (rd || wr) && (st == 2'b00);
        if (acc) begin
            for (int k = 0; k < 8; k++) begin
                ad = addr[15:0] + 16'(k);
                if (wr) begin
                    ref_mem[ad] = data[8*k +: 8];
                    exp_log.push_back('{1'b1, ad, data[8*k +: 8]});
                end else begin
                    vm[8*k +: 8] = ref_mem[ad];
                    exp_log.push_back('{1'b0, ad, ref_mem[ad]});
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                                  input logic [63:0] p, input bit iv, input bit im, input bit poke,
                                  output logic [1:0] st, output logic [63:0] vm,
                                  output int cyc, output int nreq);
        int n;
        bit seen;
        @(negedge clk);
        check_output("in_ready_idle", 64'(in_ready), 64'd1);
        act_log.delete();
        byte_no    = 0;
        waited     = 0;
        req_cycles = 0;
        icode = ic; valE = e; valA = a; valP = p;
        Instr_valid = iv; imem_error = im; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        icode = 4'($urandom); valE = {$urandom, $urandom}; valA = {$urandom, $urandom};
        valP = {$urandom, $urandom}; Instr_valid = 1'($urandom); imem_error = 1'($urandom);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (poke && n == 2) begin
                in_valid = 1'b1; icode = 4'h4; Instr_valid = 1'b1; imem_error = 1'b0;
            end
            if (n == 3) in_valid = 1'b0;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL out_valid_wait: no pulse after %0d cycles", n);
        end
        st   = stat;
        vm   = valM;
        cyc  = n + 1;
        nreq = req_cycles;
        @(negedge clk);
        check_output("out_valid_single", 64'(out_valid), 64'd0);
        check_output("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    task automatic run_checked(input string tag, input logic [3:0] ic, input logic [63:0] e,
                               input logic [63:0] a, input logic [63:0] p, input bit iv,
                               input bit im, input bit poke,
                               output logic [1:0] d_st, output logic [63:0] d_vm,
                               output int cyc, output int nreq);
        logic [1:0]  m_st;
        logic [63:0] m_vm;
        bit          acc;
        int          m_cyc;
        model_instr(ic, e, a, p, iv, im, m_st, m_vm, acc);
        apply_stimulus(ic, e, a, p, iv, im, poke && acc, d_st, d_vm, cyc, nreq);
        m_cyc = 2;
        if (acc) begin
            m_cyc = 10;
            for (int k = 0; k < 8; k++) m_cyc += waits_cfg[k];
        end
        check_output({tag, "_stat"}, 64'(d_st), 64'(m_st));
        check_output({tag, "_valM"}, d_vm, m_vm);
        check_output({tag, "_cycles"}, 64'(cyc), 64'(m_cyc));
        check_output({tag, "_ntxn"}, 64'(act_log.size()), 64'(exp_log.size()));
        for (int k = 0; k < exp_log.size() && k < act_log.size(); k++) begin
            check_output({tag, "_txn"}, 64'(act_log[k]), 64'(exp_log[k]));
        end
    endtask

    initial begin
        logic [1:0]  d_st;
        logic [63:0] d_vm;
        int          cyc;
        int          nreq;
        int          n;
        logic [63:0] call_data;

        for (int i = 0; i < 65536; i++) begin
            tb_mem[i]  = 8'(i);
            ref_mem[i] = 8'(i);
        end
        for (int k = 0; k < 8; k++) waits_cfg[k] = 0;

        rst = 1'b0; in_valid = 1'b0; icode = 4'h0; valE = 64'd0; valA = 64'd0; valP = 64'd0;
        Instr_valid = 1'b1; imem_error = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_mem_req", 64'(mem_req), 64'd0);
        check_output("rst_mem_we", 64'(mem_we), 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_output("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_valM", valM, 64'd0);
        check_output("rst_stat", 64'(stat), 64'd0);
        rst = 1'b1;

        // Directed vectors; the mrmovq and popq rows read back data written by earlier rows.
        vecs.push_back('{4'h4, 64'd58, 64'h0807060504030201, 64'd0, 1, 0, -1, 0, 2'b00, 64'd0, 10, 8});
        vecs.push_back('{4'h5, 64'd58, 64'd0, 64'd0, 1, 0, 3, 2, 2'b00, 64'h0807060504030201, 12, 10});
        vecs.push_back('{4'h9, 64'd0, 64'd65528, 64'd0, 1, 0, -1, 0, 2'b00, 64'hFFFEFDFCFBFAF9F8, 10, 8});
        vecs.push_back('{4'h9, 64'd0, 64'd65529, 64'd0, 1, 0, -1, 0, 2'b10, 64'd0, 2, 0});
        vecs.push_back('{4'h4, 64'd58, 64'd1, 64'd0, 0, 1, -1, 0, 2'b10, 64'd0, 2, 0});
        vecs.push_back('{4'h4, 64'd58, 64'd1, 64'd0, 0, 0, -1, 0, 2'b11, 64'd0, 2, 0});
        vecs.push_back('{4'h0, 64'd58, 64'd1, 64'd0, 1, 0, -1, 0, 2'b01, 64'd0, 2, 0});
        vecs.push_back('{4'h6, 64'd58, 64'd1, 64'd0, 1, 0, -1, 0, 2'b00, 64'd0, 2, 0});
        vecs.push_back('{4'hB, 64'd0, 64'h10000, 64'd0, 1, 0, -1, 0, 2'b10, 64'd0, 2, 0});
        vecs.push_back('{4'hA, 64'h8000000000000100, 64'd5, 64'd0, 1, 0, -1, 0, 2'b10, 64'd0, 2, 0});
        vecs.push_back('{4'h8, 64'd65528, 64'd0, 64'h1122334455667788, 1, 0, -1, 0, 2'b00, 64'd0, 10, 8});
        vecs.push_back('{4'hB, 64'd0, 64'd65528, 64'd0, 1, 0, -1, 0, 2'b00, 64'h1122334455667788, 10, 8});

        for (int v = 0; v < vecs.size(); v++) begin
            for (int k = 0; k < 8; k++) waits_cfg[k] = (k == vecs[v].wait_byte) ? vecs[v].wait_n : 0;
            run_checked($sformatf("vec%0d", v), vecs[v].ic, vecs[v].e, vecs[v].a, vecs[v].p,
                        vecs[v].iv, vecs[v].im, 1'b0, d_st, d_vm, cyc, nreq);
            check_output($sformatf("vec%0d_stat_const", v), 64'(d_st), 64'(vecs[v].exp_stat));
            check_output($sformatf("vec%0d_valM_const", v), d_vm, vecs[v].exp_valm);
            check_output($sformatf("vec%0d_cyc_const", v), 64'(cyc), 64'(vecs[v].exp_cyc));
            check_output($sformatf("vec%0d_nreq_const", v), 64'(nreq), 64'(vecs[v].exp_nreq));
        end
        for (int k = 0; k < 8; k++) waits_cfg[k] = 0;

        // Reset lands after five bytes of a call; those bytes stay written.
        call_data = 64'hA1A2A3A4A5A6A7A8;
        act_log.delete();
        byte_no = 0; waited = 0; req_cycles = 0;
        @(negedge clk);
        icode = 4'h8; valE = 64'd100; valA = 64'd0; valP = call_data;
        Instr_valid = 1'b1; imem_error = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (act_log.size() < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("rst_mid_bytes", 64'(act_log.size()), 64'd5);
        check_output("rst_mid_req_before", 64'(mem_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_output("rst_mid_req", 64'(mem_req), 64'd0);
        check_output("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_mid_we", 64'(mem_we), 64'd0);
        check_output("rst_mid_addr", 64'(mem_addr), 64'd0);
        check_output("rst_mid_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) ref_mem[100 + k] = call_data[8*k +: 8];
        run_checked("post_rst", 4'h5, 64'd100, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, d_st, d_vm, cyc, nreq);
        check_output("post_rst_valM_const", d_vm, 64'h6B6A69A4A5A6A7A8);

`ifdef MEM_TIMEOUT_EN
        // Ack withheld entirely: the watchdog must give up after sixteen request cycles.
        hold_low = 1'b1;
        apply_stimulus(4'hA, 64'd200, 64'h1234, 64'd0, 1'b1, 1'b0, 1'b0, d_st, d_vm, cyc, nreq);
        hold_low = 1'b0;
        check_output("timeout_stat", 64'(d_st), 64'd2);
        check_output("timeout_valM", d_vm, 64'd0);
        check_output("timeout_req_cycles", 64'(nreq), 64'd16);
        check_output("timeout_cycles", 64'(cyc), 64'd18);
        check_output("timeout_no_txn", 64'(act_log.size()), 64'd0);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [3:0]  ic;
            logic [63:0] e;
            logic [63:0] a;
            logic [63:0] p;
            int          mode;
            logic [3:0]  acc_list [6];
            acc_list = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
            ic = ($urandom_range(0, 9) < 7) ? acc_list[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 9);
            if (mode <= 6)       e = 64'($urandom_range(0, 65535));
            else if (mode == 7)  e = 64'(65520 + $urandom_range(0, 15));
            else if (mode == 8)  e = {$urandom, $urandom};
            else                 e = 64'($urandom_range(0, 65535)) | (64'd1 << $urandom_range(16, 63));
            a = ($urandom_range(0, 1) == 1) ? e : 64'($urandom_range(0, 65528));
            if (ic == 4'h9 || ic == 4'hB) begin
                logic [63:0] tmp;
                tmp = a; a = e; e = tmp;
            end
            p = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) waits_cfg[k] = (t % 3 == 0) ? 0 : $urandom_range(0, 2);
            run_checked($sformatf("rnd%0d", t), ic, e, a, p, ($urandom_range(0, 19) != 0),
                        ($urandom_range(0, 24) == 0), 1'($urandom), d_st, d_vm, cyc, nreq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
